// File: rtl/note_sequencer.sv
// note_sequencer
//
// Plays a programmable table of (note, duration) entries, one step per tempo
// tick. Each entry sounds for `dur` ticks with gate high, followed by one tick
// of articulation silence (gate low, note held), then the next entry. An entry
// with dur = 0 marks the end of the sequence. At the end the sequencer either
// restarts at entry 0 (loop = 1) or returns to idle and pulses done.
//
// Parameters:
//   DEPTH   table entries (power of two, >= 2)
//   AW      table address width, log2(DEPTH)
//   NOTE_W  note code width
//   DUR_W   duration field width, in ticks
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset; also clears the table
//   tick      single-cycle tempo enable
//   wr_en     table write strobe (accepted only while idle)
//   wr_addr   table write address
//   wr_note   note code to write
//   wr_dur    duration to write; 0 = end-of-sequence marker
//   start     begin playback from entry 0 when idle
//   stop      abort playback; overrides start and tick
//   loop      sampled at end of sequence; 1 = restart at entry 0
//   note      current note code (0 while idle)
//   gate      high while a note sounds
//   step_idx  index of the current entry (0 while idle)
//   busy      high in any state except idle
//   done      one-cycle pulse on natural completion
//   wr_err    one-cycle pulse when a write is dropped

module note_sequencer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned NOTE_W = 7,
    parameter int unsigned DUR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [NOTE_W-1:0] wr_note,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [NOTE_W-1:0] note,
    output logic              gate,
    output logic [AW-1:0]     step_idx,
    output logic              busy,
    output logic              done,
    output logic              wr_err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StNote = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    // Sequence table
    logic [NOTE_W-1:0] tbl_note_q [DEPTH];
    logic [DUR_W-1:0]  tbl_dur_q  [DEPTH];

    // Control state and registered outputs
    logic [1:0]        state_q, state_d;
    logic [DUR_W-1:0]  rem_q, rem_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              gate_q, gate_d;
    logic [AW-1:0]     step_q, step_d;
    logic              done_q, done_d;
    logic              wr_err_q, wr_err_d;

    logic              is_idle;
    logic              wr_ok;
    logic [AW-1:0]     nxt_idx;
    logic              is_last;
    logic              load_en;
    logic [AW-1:0]     load_idx;

    assign is_idle = (state_q == StIdle);
    assign wr_ok   = wr_en && is_idle;
    assign nxt_idx = step_q + AW'(1);
    assign is_last = (step_q == LastIdx);

    // ------------------------------------------------------------------
    // Table storage. A write in the same cycle as start lands here, while
    // the start decision below still sees the pre-write contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl_note_q[i] <= '0;
                tbl_dur_q[i]  <= '0;
            end
        end else if (wr_ok) begin
            tbl_note_q[wr_addr] <= wr_note;
            tbl_dur_q[wr_addr]  <= wr_dur;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        note_d   = note_q;
        gate_d   = gate_q;
        step_d   = step_q;
        done_d   = 1'b0;
        wr_err_d = wr_en && !is_idle;
        load_en  = 1'b0;
        load_idx = '0;

        if (stop) begin
            state_d = StIdle;
            rem_d   = '0;
            note_d  = '0;
            gate_d  = 1'b0;
            step_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (tbl_dur_q[0] != '0) begin
                            load_en  = 1'b1;
                            load_idx = '0;
                        end else begin
                            // Empty sequence: complete at once, gate never rises
                            done_d = 1'b1;
                        end
                    end
                end

                StNote: begin
                    if (tick) begin
                        if (rem_q == DUR_W'(1)) begin
                            state_d = StGap;
                            gate_d  = 1'b0;
                            rem_d   = '0;
                        end else begin
                            rem_d = rem_q - DUR_W'(1);
                        end
                    end
                end

                StGap: begin
                    if (tick) begin
                        if (!is_last && tbl_dur_q[nxt_idx] != '0) begin
                            load_en  = 1'b1;
                            load_idx = nxt_idx;
                        end else if (loop && tbl_dur_q[0] != '0) begin
                            // Entry 0 may have been cleared by a write in the
                            // start cycle; never re-enter NOTE with dur = 0.
                            load_en  = 1'b1;
                            load_idx = '0;
                        end else begin
                            state_d = StIdle;
                            note_d  = '0;
                            step_d  = '0;
                            done_d  = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = StIdle;
                    rem_d   = '0;
                    note_d  = '0;
                    gate_d  = 1'b0;
                    step_d  = '0;
                end
            endcase

            if (load_en) begin
                state_d = StNote;
                note_d  = tbl_note_q[load_idx];
                rem_d   = tbl_dur_q[load_idx];
                gate_d  = 1'b1;
                step_d  = load_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rem_q    <= '0;
            note_q   <= '0;
            gate_q   <= 1'b0;
            step_q   <= '0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            note_q   <= note_d;
            gate_q   <= gate_d;
            step_q   <= step_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign note     = note_q;
    assign gate     = gate_q;
    assign step_idx = step_q;
    assign busy     = !is_idle;
    assign done     = done_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a behavioural model that tracks
// playback as (entry index, ticks elapsed within the entry).

module tb_note_sequencer;

    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int NOTE_W = 7;
    localparam int DUR_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tick, wr_en, start, stop, loop;
    logic [AW-1:0]     wr_addr;
    logic [NOTE_W-1:0] wr_note;
    logic [DUR_W-1:0]  wr_dur;
    logic [NOTE_W-1:0] note;
    logic              gate;
    logic [AW-1:0]     step_idx;
    logic              busy, done, wr_err;

    always #5 clk = ~clk;

    note_sequencer #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .NOTE_W(NOTE_W),
        .DUR_W (DUR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_note (wr_note),
        .wr_dur  (wr_dur),
        .start   (start),
        .stop    (stop),
        .loop    (loop),
        .note    (note),
        .gate    (gate),
        .step_idx(step_idx),
        .busy    (busy),
        .done    (done),
        .wr_err  (wr_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an entry occupies dur+1 ticks; elapsed count t < dur
    // means sounding, t == dur is the silent tick, t == dur+1 moves on.
    // ------------------------------------------------------------------
    int m_tbl_note [DEPTH];
    int m_tbl_dur  [DEPTH];
    bit m_busy;
    int m_idx, m_t, m_cur_note, m_cur_dur;
    bit m_done, m_wr_err;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_tbl_note[i] = 0;
            m_tbl_dur[i]  = 0;
        end
        m_busy = 0; m_idx = 0; m_t = 0; m_cur_note = 0; m_cur_dur = 0;
        m_done = 0; m_wr_err = 0;
    endtask

    task automatic model_load(input int i);
        m_busy     = 1;
        m_idx      = i;
        m_t        = 0;
        m_cur_note = m_tbl_note[i];
        m_cur_dur  = m_tbl_dur[i];
    endtask

    task automatic model_edge();
        bit was_busy;
        if (!rst_n) begin
            model_reset();
            return;
        end
        was_busy = m_busy;
        m_done   = 0;
        m_wr_err = wr_en && was_busy;
        if (stop) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (start) begin
                if (m_tbl_dur[0] != 0) model_load(0);
                else m_done = 1;
            end
        end else if (tick) begin
            m_t++;
            if (m_t == m_cur_dur + 1) begin
                if (m_idx < DEPTH - 1 && m_tbl_dur[m_idx + 1] != 0) model_load(m_idx + 1);
                else if (loop && m_tbl_dur[0] != 0) model_load(0);
                else begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
        if (wr_en && !was_busy) begin
            m_tbl_note[wr_addr] = int'(wr_note);
            m_tbl_dur[wr_addr]  = int'(wr_dur);
        end
    endtask

    task automatic compare_outs();
        check_eq("note",     32'(note),     32'(m_busy ? m_cur_note : 0));
        check_eq("gate",     32'(gate),     32'(m_busy && (m_t < m_cur_dur)));
        check_eq("step_idx", 32'(step_idx), 32'(m_busy ? m_idx : 0));
        check_eq("busy",     32'(busy),     32'(m_busy));
        check_eq("done",     32'(done),     32'(m_done));
        check_eq("wr_err",   32'(wr_err),   32'(m_wr_err));
    endtask

    // One clock: model advances on the same edge, DUT sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_outs();
    endtask

    task automatic idle_inputs();
        tick = 0; wr_en = 0; start = 0; stop = 0;
        wr_addr = '0; wr_note = '0; wr_dur = '0;
    endtask

    task automatic write_entry(input int a, input int n, input int d);
        wr_en = 1; wr_addr = AW'(a); wr_note = NOTE_W'(n); wr_dur = DUR_W'(d);
        step();
        wr_en = 0;
    endtask

    task automatic do_start();
        start = 1;
        step();
        start = 0;
    endtask

    // Per-note and per-step sounding-tick histograms gathered by run_play.
    int hist_note [128];
    int hist_step [DEPTH];

    task automatic run_play(input int max_cyc, input int tick_per,
                            output int ticks, output int dones, output bit timed_out);
        ticks = 0; dones = 0; timed_out = 1;
        foreach (hist_note[i]) hist_note[i] = 0;
        foreach (hist_step[i]) hist_step[i] = 0;
        for (int c = 0; c < max_cyc; c++) begin
            tick = ((c % tick_per) == tick_per - 1);
            if (tick && gate) begin
                hist_note[note]++;
                hist_step[step_idx]++;
            end
            if (tick && busy) ticks++;
            step();
            if (done) dones++;
            if (!busy) begin
                timed_out = 0;
                break;
            end
        end
        tick = 0;
    endtask

    task automatic program_basic();
        write_entry(0, 60, 2);
        write_entry(1, 64, 1);
        write_entry(2, 67, 3);
        write_entry(3, 0, 0);
    endtask

    int ticks, dones;
    bit to;

    initial begin
        idle_inputs();
        loop  = 0;
        rst_n = 0;
        model_reset();
        #12;
        check_eq("rst_note", 32'(note), 0);
        check_eq("rst_gate", 32'(gate), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        rst_n = 1;
        step();

        // Basic sequence, no loop
        program_basic();
        do_start();
        check_eq("s1_start_gate", 32'(gate), 1);
        check_eq("s1_start_note", 32'(note), 60);
        run_play(200, 3, ticks, dones, to);
        check_eq("s1_end",    32'(to), 0);
        check_eq("s1_ticks",  32'(ticks), 9);
        check_eq("s1_dones",  32'(dones), 1);
        check_eq("s1_gate60", 32'(hist_note[60]), 2);
        check_eq("s1_gate64", 32'(hist_note[64]), 1);
        check_eq("s1_gate67", 32'(hist_note[67]), 3);

        // Looping: never completes
        loop = 1;
        do_start();
        run_play(120, 2, ticks, dones, to);
        check_eq("s2_still_busy", 32'(busy), 1);
        check_eq("s2_dones", 32'(dones), 0);
        check_eq("s2_relooped", 32'(hist_note[60] >= 4), 1);

        // Stop together with tick mid-note
        stop = 1; step(); stop = 0;
        loop = 0;
        do_start();
        tick = 1; step(); tick = 0;
        check_eq("s3_mid_gate", 32'(gate), 1);
        stop = 1; tick = 1; step(); stop = 0; tick = 0;
        check_eq("s3_gate", 32'(gate), 0);
        check_eq("s3_note", 32'(note), 0);
        check_eq("s3_busy", 32'(busy), 0);
        check_eq("s3_done", 32'(done), 0);

        // Write while busy is dropped
        do_start();
        write_entry(1, 72, 1);
        check_eq("s4_wr_err", 32'(wr_err), 1);
        step();
        check_eq("s4_wr_err_pulse", 32'(wr_err), 0);
        run_play(200, 2, ticks, dones, to);
        check_eq("s4_played64", 32'(hist_note[64]), 1);
        check_eq("s4_not72", 32'(hist_note[72]), 0);

        // Write and start in the same idle cycle: step 0 uses old entry 0
        wr_en = 1; wr_addr = '0; wr_note = 7'd50; wr_dur = 4'd3; start = 1;
        step();
        wr_en = 0; start = 0;
        check_eq("s4b_old_note", 32'(note), 60);
        run_play(200, 2, ticks, dones, to);
        check_eq("s4b_end", 32'(to), 0);

        // Full table, maximum duration
        for (int i = 0; i < DEPTH; i++) write_entry(i, 40 + i, 15);
        do_start();
        run_play(800, 2, ticks, dones, to);
        check_eq("s5_end", 32'(to), 0);
        check_eq("s5_ticks", 32'(ticks), DEPTH * 16);
        check_eq("s5_dones", 32'(dones), 1);
        for (int i = 0; i < DEPTH; i++) check_eq("s5_step_gate", 32'(hist_step[i]), 15);

        // Empty sequence
        write_entry(0, 55, 0);
        do_start();
        check_eq("s6_done", 32'(done), 1);
        check_eq("s6_gate", 32'(gate), 0);
        check_eq("s6_busy", 32'(busy), 0);

        // Reset mid-note clears everything, including the table
        program_basic();
        do_start();
        tick = 1; step(); tick = 0;
        step();
        #2 rst_n = 0;
        model_reset();
        #1;
        check_eq("s7_note", 32'(note), 0);
        check_eq("s7_gate", 32'(gate), 0);
        check_eq("s7_busy", 32'(busy), 0);
        check_eq("s7_step", 32'(step_idx), 0);
        step();
        @(negedge clk) rst_n = 1;
        do_start();
        check_eq("s7_done", 32'(done), 1);
        check_eq("s7_nobusy", 32'(busy), 0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            tick  = ($urandom_range(0, 2) == 0);
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) loop = ~loop;
            wr_en = ($urandom_range(0, 7) == 0);
            wr_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_note = NOTE_W'($urandom_range(0, 127));
            wr_dur  = ($urandom_range(0, 5) == 0) ? '0 : DUR_W'($urandom_range(1, 15));
            step();
        end
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Tempo-driven note sequencer that plays a small programmable table of (note, duration) entries, one step per tempo tick. It consumes the single-cycle tick produced by the clock-enable generator, typically the 32 Hz tempo pulse at 100 MHz. It drives a note code plus gate to the tone generator. It sequences the tone datapath: it owns start, stop, loop and articulation, and the tone generator only follows `note`/`gate`.

## Interface
- DEPTH, 16: table entries; power of two, at least 2
- AW, 4: address width, log2(DEPTH)
- NOTE_W, 7: note code width (MIDI note number)
- DUR_W, 4: duration field width, in ticks
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  single-cycle tempo enable from the enable generator
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write address
- wr_note  in  NOTE_W  note code to write
- wr_dur  in  DUR_W  duration to write; 0 = end-of-sequence marker
- start  in  1  level sampled each cycle; begins playback from entry 0 when idle
- stop  in  1  abort playback
- loop  in  1  sampled at end of sequence; 1 = restart at entry 0
- note  out  NOTE_W  current note code
- gate  out  1  1 while a note sounds
- step_idx  out  AW  index of current entry
- busy  out  1  1 in any state except IDLE
- done  out  1  one-cycle pulse on natural (non-stop) completion
- wr_err  out  1  one-cycle pulse when a write is dropped

## Operation
- Table: DEPTH registers of {note, dur}; all cleared to 0 by reset.
- Writes are accepted only in IDLE. A write while `busy` is dropped, and `wr_err` pulses the next cycle.
- States: IDLE, NOTE, GAP.
- IDLE to NOTE: `start`=1 and `stop`=0 and entry 0 dur≠0. The block loads `note`, `gate`=1, `step_idx`=0, and remaining count `rem`=dur.
- IDLE with `start` and entry 0 dur=0: stays IDLE, `done` pulses, `gate` never rises.
- NOTE, on `tick`: if `rem`=1, go to GAP with `gate`=0. Otherwise `rem` decrements. `gate` is high for exactly dur ticks.
- GAP, on `tick`: one-tick articulation silence, then advance.
  - next = `step_idx`+1, unless `step_idx`=DEPTH-1, which counts as end.
  - If not end and entry[next] dur≠0: go to NOTE with that entry.
  - If end or entry[next] dur=0 and `loop`=1: go to NOTE with entry 0.
  - Otherwise: go to IDLE and pulse `done`.
- `stop`, from any state: next cycle IDLE, `gate`=0, `note`=0, `step_idx`=0, no `done`. `stop` overrides `start` and `tick` in the same cycle.
- `start` while busy is ignored.
- `tick` in IDLE is ignored.
- `note` holds its value through GAP and is 0 in IDLE.

## Timing
- Reset values: `note`=0, `gate`=0, `step_idx`=0, `busy`=0, `done`=0, `wr_err`=0, state IDLE, `rem`=0.
- All outputs are registered.
- Start latency: `start` sampled at edge N; `gate`, `busy` and `note` are valid after edge N. There is no wait for a tick.
- Step changes occur on the edge where `tick` is sampled high.
- Total sequence length = sum of (dur+1) ticks. No extra cycle is inserted between a GAP and the next NOTE.
- Write and `start` in the same idle cycle: the write lands in the table, but playback uses the pre-write contents of entry 0 for step 0. Later steps read the new contents.
- `done` is asserted in the same cycle `busy` falls.
- `rem` is DUR_W wide. A dur of 2^DUR_W−1 must count fully, with no wrap.
- Reset mid-playback: immediate return to IDLE with all outputs at reset values, and the table cleared.

## Test plan
- Program {60,2},{64,1},{67,3},{0,0}, `loop`=0, `start`. Expect:
  - `gate` high 2 ticks at 60, low 1, high 1 at 64, low 1, high 3 at 67, low 1.
  - `done` pulse once, `busy`=0 after 9 ticks total.
- Same table with `loop`=1. Expect entry 0 (note 60) re-enters NOTE on the tick ending the GAP of entry 2, with no `done`.
- `stop` asserted mid-note with `tick` in the same cycle. Expect next cycle `gate`=0, `note`=0, `busy`=0, and no `done`.
- Write while busy (addr 1, note 72). Expect `wr_err` pulse, and entry 1 still plays 64.
- All DEPTH entries non-zero, dur=15, `loop`=0. Expect step_idx 0..15 each with 15 gate ticks, then `done` after the GAP of entry 15.
- `start` with entry 0 dur=0. Expect `done` pulse, and `gate`/`busy` stay 0.
- Reset asserted mid-NOTE. Expect all outputs 0 asynchronously; after release, `start` yields immediate `done`.
